nibble_serial_adder: RTL

Multi-cycle wide adder controller built around the existing 4-bit `adder` (ports `Sum`, `co`, `A`, `B`, `cin`). It latches two `4*NIBBLES`-bit operands, feeds the 4-bit `adder` one nibble per cycle (LSB first) and registers the carry between nibbles. It then consumes the adder's `Sum`/`co` to assemble the full-width result. The block sits directly upstream and downstream of the `adder` instance: it drives the adder's inputs and captures its outputs.

---
 rtl/nibble_serial_adder.sv | 110 +++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle wide adder controller wrapped around an external 4-bit
//   combinational adder. It latches two W-bit operands (W = 4*NIBBLES) and a
//   carry-in. It then feeds the adder one nibble per cycle, LSB first, and
//   registers the carry between nibbles. The adder's Sum/co are collected
//   into the full-width result.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             operation request, sampled only in IDLE
//   A, B, cin         operands, captured when start is accepted
//   add_A/add_B       current operand nibbles to the adder (0 outside RUN)
//   add_cin           registered inter-nibble carry to the adder (0 outside RUN)
//   add_Sum, add_co   adder outputs, combinational in the same cycle
//   busy              high while nibbles are being processed
//   done              one-cycle pulse after the last nibble
//   Sum, co           result; held between operations
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 cin,
  output logic [3:0]           add_A,
  output logic [3:0]           add_B,
  output logic                 add_cin,
  input  logic [3:0]           add_Sum,
  input  logic                 add_co,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 co
);

  localparam int W  = 4*NIBBLES;
  localparam int CW = $clog2(NIBBLES+1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(NIBBLES-1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_sh, b_sh, s_sh, s_nxt;
  logic          c_r;

  // Result shifts in from the top so that after NIBBLES steps the first
  // nibble has reached bit 0. A single-nibble build has nothing to shift.
  generate
    if (NIBBLES == 1) begin : g_one
      assign s_nxt = add_Sum;
    end else begin : g_many
      assign s_nxt = {add_Sum, s_sh[W-1:4]};
    end
  endgenerate

  // Adder inputs come straight from registers; gated so the adder sees
  // zeros whenever no operation is in flight.
  assign add_A   = (state == RUN) ? a_sh[3:0] : 4'd0;
  assign add_B   = (state == RUN) ? b_sh[3:0] : 4'd0;
  assign add_cin = (state == RUN) ? c_r       : 1'b0;
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c_r   <= 1'b0;
      Sum   <= '0;
      co    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            c_r   <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s_sh <= s_nxt;
          c_r  <= add_co;
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Sum/co move only here, so they hold through the RUN phase
            Sum   <= s_nxt;
            co    <= add_co;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
